sdram_port_arbiter: RTL



---
 rtl/sdram_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// N-channel SDRAM port arbiter: one strict-priority channel, round-robin among the rest, slot-timed accesses.
// Optional per-channel grant counters on stat_grants when ARB_STATS_EN is defined.
module sdram_port_arbiter #(
    parameter int NCH         = 3,
    parameter int AW          = 25,
    parameter int DW          = 8,
    parameter int SLOT_CYCLES = 2,
    parameter int PRIO_CH     = 0
) (
    input  logic              F14M,
    input  logic              RESET,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] din,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     rdata,
    output logic [NCH-1:0]    rvalid,
    output logic [AW-1:0]     sd_addr,
    output logic [DW-1:0]     sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [DW-1:0]     sd_dout
`ifdef ARB_STATS_EN
    ,
    output logic [NCH*16-1:0] stat_grants
`endif
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(SLOT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            we_lat_q, we_lat_d;
    logic [AW-1:0]   sd_addr_q, sd_addr_d;
    logic [DW-1:0]   sd_din_q, sd_din_d;
    logic            sd_we_q, sd_we_d;
    logic            sd_oe_q, sd_oe_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic [NCH-1:0]  rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            found;
    logic [IW-1:0]   win, cand, rr_nxt;

    function automatic logic [IW-1:0] wrap_idx(input int v);
        return IW'(v % NCH);
    endfunction

    // Winner selection: priority channel first, else first requester at or after rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        found  = 1'b0;
        win    = '0;
        cand   = '0;
        if (req[PRIO_CH]) begin
            found = 1'b1;
            win   = IW'(PRIO_CH);
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cand = wrap_idx(int'(rr_ptr_q) + k);
                if (!found && cand != IW'(PRIO_CH) && req[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        rr_nxt = wrap_idx(int'(win) + 1);
        if (rr_nxt == IW'(PRIO_CH))
            rr_nxt = wrap_idx(int'(win) + 2);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        we_lat_d  = we_lat_q;
        sd_addr_d = sd_addr_q;
        sd_din_d  = sd_din_q;
        sd_we_d   = sd_we_q;
        sd_oe_d   = sd_oe_q;
        ack_d     = '0;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                sd_we_d = 1'b0;
                sd_oe_d = 1'b0;
                if (found) begin
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    gnt_d     = win;
                    we_lat_d  = we[win];
                    sd_addr_d = addr[int'(win)*AW +: AW];
                    sd_din_d  = din[int'(win)*DW +: DW];
                    sd_we_d   = we[win];
                    sd_oe_d   = ~we[win];
                    if (win != IW'(PRIO_CH))
                        rr_ptr_d = rr_nxt;
                end
            end
            ACCESS: begin
                // The last slot cycle registers ack/rvalid/rdata so they appear together in DONE.
                if (cnt_q == CW'(SLOT_CYCLES - 1)) begin
                    state_d       = DONE;
                    sd_we_d       = 1'b0;
                    sd_oe_d       = 1'b0;
                    ack_d[gnt_q]  = 1'b1;
                    if (!we_lat_q) begin
                        rvalid_d[gnt_q] = 1'b1;
                        rdata_d         = sd_dout;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge F14M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            we_lat_q  <= 1'b0;
            sd_addr_q <= '0;
            sd_din_q  <= '0;
            sd_we_q   <= 1'b0;
            sd_oe_q   <= 1'b0;
            ack_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            we_lat_q  <= we_lat_d;
            sd_addr_q <= sd_addr_d;
            sd_din_q  <= sd_din_d;
            sd_we_q   <= sd_we_d;
            sd_oe_q   <= sd_oe_d;
            ack_q     <= ack_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign ack     = ack_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign sd_addr = sd_addr_q;
    assign sd_din  = sd_din_q;
    assign sd_we   = sd_we_q;
    assign sd_oe   = sd_oe_q;

`ifdef ARB_STATS_EN
    logic [NCH*16-1:0] stat_q, stat_d;

    // Saturating per-channel grant counters.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NCH; i++) begin
            if (ack_q[i] && stat_q[i*16 +: 16] != 16'hFFFF)
                stat_d[i*16 +: 16] = stat_q[i*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge F14M) begin
        if (RESET) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_grants = stat_q;
`endif

endmodule
